// File: rtl/fphub_mult_issuer.sv
`default_nettype none
// ============================================================================
// Module      : fphub_mult_issuer (with local fpnew_pkg subset)
// Description : Initiator-side front end for the HUB multiplier's FPnew-style
//               port. Accepts tagged operand pairs and issues them as MUL
//               operations. Results and flags come back in order, with their
//               tags, through a result FIFO. Credit-based issue guarantees
//               there is always room for a result, so out_ready_o only drops
//               during a flush.
// Build option: FPHUB_ISSUER_FFLAGS_EN - when defined, fflags_o is a sticky
//               OR of all captured status flags (cleared by fflags_clr_i);
//               when undefined, fflags_o is tied to 0.
// Ports       : clk_i/rst_i        clock, async active-high reset
//               req_*              upstream request handshake {A, B, tag}
//               flush_i            abort all pending work (pulse)
//               operands_o, op_o,
//               op_mod_o, in_*     issue handshake toward the multiplier
//               flush_o            one-cycle flush toward the multiplier
//               result_i, status_i,
//               out_*              result handshake from the multiplier
//               rsp_*              in-order tagged response handshake
//               fflags_o/_clr_i    sticky exception flags and clear
// Revision    : 1.0 - initial release
// ============================================================================

package fpnew_pkg;
   typedef enum logic [3:0] {
      FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
      CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
   } operation_e;

   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;
endpackage

module fphub_mult_issuer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [WIDTH-1:0]            req_a_i,
   input  logic [WIDTH-1:0]            req_b_i,
   input  logic [TAG_W-1:0]            req_tag_i,
   input  logic                        flush_i,
   output logic [2:0][WIDTH-1:0]       operands_o,
   output fpnew_pkg::operation_e       op_o,
   output logic                        op_mod_o,
   output logic                        in_valid_o,
   input  logic                        in_ready_i,
   output logic                        flush_o,
   input  logic [WIDTH-1:0]            result_i,
   input  fpnew_pkg::status_t          status_i,
   input  logic                        out_valid_i,
   output logic                        out_ready_o,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [WIDTH-1:0]            rsp_result_o,
   output logic [4:0]                  rsp_status_o,
   output logic [TAG_W-1:0]            rsp_tag_o,
   output logic [4:0]                  fflags_o,
   input  logic                        fflags_clr_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   state_e state_q, state_d;
   logic   w_run;
   logic   w_open;
   logic   w_clear;

   // Issue register
   logic               iss_v_q, iss_v_d;
   logic [WIDTH-1:0]   iss_a_q, iss_a_d;
   logic [WIDTH-1:0]   iss_b_q, iss_b_d;
   logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;

   // Outstanding-transaction counter
   logic [CNT_W-1:0]   inflight_q, inflight_d;

   // Tag FIFO (tags of issued but not yet captured operations)
   logic [TAG_W-1:0]   tag_mem_q [DEPTH];
   logic [PTR_W-1:0]   tag_wr_q, tag_wr_d;
   logic [PTR_W-1:0]   tag_rd_q, tag_rd_d;
   logic [CNT_W-1:0]   tag_cnt_q, tag_cnt_d;

   // Result FIFO
   logic [WIDTH-1:0]   res_data_q [DEPTH];
   logic [4:0]         res_st_q   [DEPTH];
   logic [TAG_W-1:0]   res_tag_q  [DEPTH];
   logic [PTR_W-1:0]   res_wr_q, res_wr_d;
   logic [PTR_W-1:0]   res_rd_q, res_rd_d;
   logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

   logic               w_req_fire;
   logic               w_issue_fire;
   logic               w_capture;
   logic               w_rsp_fire;
   logic               w_credit_ok;
   logic               w_tag_bypass;
   logic               w_tag_push;
   logic               w_tag_pop;
   logic [TAG_W-1:0]   w_cap_tag;
   logic [4:0]         w_status;

   assign w_status = status_i;

   // -------------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      w_run   = 1'b0;
      flush_o = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            w_run = 1'b1;
            if (flush_i) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush_o = 1'b1;
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Handshakes are closed while reset is held so nothing is accepted then.
   assign w_open  = w_run && !rst_i;
   assign w_clear = (state_q == ST_FLUSH);

   // A new issue is allowed only if its result is guaranteed a FIFO slot.
   assign w_credit_ok  = ({1'b0, inflight_q} + {1'b0, res_cnt_q}) < (CNT_W + 1)'(DEPTH);
   assign in_valid_o   = w_run && iss_v_q && w_credit_ok;
   assign w_issue_fire = in_valid_o && in_ready_i;
   assign req_ready_o  = w_open && (!iss_v_q || w_issue_fire);
   assign w_req_fire   = req_valid_i && req_ready_o;
   assign out_ready_o  = w_open;
   assign w_capture    = out_valid_i && out_ready_o;
   assign rsp_valid_o  = w_run && (res_cnt_q != '0);
   assign w_rsp_fire   = rsp_valid_o && rsp_ready_i;

   assign operands_o[0] = iss_a_q;
   assign operands_o[1] = iss_b_q;
   assign operands_o[2] = '0;
   assign op_o          = fpnew_pkg::MUL;
   assign op_mod_o      = 1'b0;

   // A combinational unit returns the result in the issue cycle itself; with
   // no older tags queued, the tag is taken straight from the issue register.
   assign w_tag_bypass = (tag_cnt_q == '0);
   assign w_cap_tag    = w_tag_bypass ? iss_tag_q : tag_mem_q[tag_rd_q];
   assign w_tag_push   = w_issue_fire && !(w_capture && w_tag_bypass);
   assign w_tag_pop    = w_capture && !w_tag_bypass;

   // -------------------------------------------------------------------------
   // Issue register and in-flight counter
   // -------------------------------------------------------------------------
   always_comb begin
      iss_v_d    = iss_v_q;
      iss_a_d    = iss_a_q;
      iss_b_d    = iss_b_q;
      iss_tag_d  = iss_tag_q;
      inflight_d = inflight_q;
      if (w_clear) begin
         iss_v_d    = 1'b0;
         inflight_d = '0;
      end else begin
         if (w_issue_fire) begin
            iss_v_d = 1'b0;
         end
         // Only loaded on acceptance, so operands hold during in_ready_i stalls.
         if (w_req_fire) begin
            iss_v_d   = 1'b1;
            iss_a_d   = req_a_i;
            iss_b_d   = req_b_i;
            iss_tag_d = req_tag_i;
         end
         unique case ({w_issue_fire, w_capture})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         iss_v_q    <= 1'b0;
         iss_a_q    <= '0;
         iss_b_q    <= '0;
         iss_tag_q  <= '0;
         inflight_q <= '0;
      end else begin
         iss_v_q    <= iss_v_d;
         iss_a_q    <= iss_a_d;
         iss_b_q    <= iss_b_d;
         iss_tag_q  <= iss_tag_d;
         inflight_q <= inflight_d;
      end
   end

   // -------------------------------------------------------------------------
   // Tag FIFO and result FIFO pointers
   // -------------------------------------------------------------------------
   always_comb begin
      tag_wr_d  = tag_wr_q;
      tag_rd_d  = tag_rd_q;
      tag_cnt_d = tag_cnt_q;
      res_wr_d  = res_wr_q;
      res_rd_d  = res_rd_q;
      res_cnt_d = res_cnt_q;
      if (w_clear) begin
         tag_wr_d  = '0;
         tag_rd_d  = '0;
         tag_cnt_d = '0;
         res_wr_d  = '0;
         res_rd_d  = '0;
         res_cnt_d = '0;
      end else begin
         if (w_tag_push) begin
            tag_wr_d = tag_wr_q + PTR_W'(1);
         end
         if (w_tag_pop) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
         end
         unique case ({w_tag_push, w_tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
            default: tag_cnt_d = tag_cnt_q;
         endcase

         if (w_capture) begin
            res_wr_d = res_wr_q + PTR_W'(1);
         end
         if (w_rsp_fire) begin
            res_rd_d = res_rd_q + PTR_W'(1);
         end
         unique case ({w_capture, w_rsp_fire})
            2'b10:   res_cnt_d = res_cnt_q + CNT_W'(1);
            2'b01:   res_cnt_d = res_cnt_q - CNT_W'(1);
            default: res_cnt_d = res_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_wr_q  <= '0;
         tag_rd_q  <= '0;
         tag_cnt_q <= '0;
         res_wr_q  <= '0;
         res_rd_q  <= '0;
         res_cnt_q <= '0;
      end else begin
         tag_wr_q  <= tag_wr_d;
         tag_rd_q  <= tag_rd_d;
         tag_cnt_q <= tag_cnt_d;
         res_wr_q  <= res_wr_d;
         res_rd_q  <= res_rd_d;
         res_cnt_q <= res_cnt_d;
      end
   end

   // Storage needs no reset: entries are only read behind a non-zero count,
   // and the response data outputs are forced to zero when not valid.
   always_ff @(posedge clk_i) begin
      if (w_tag_push) begin
         tag_mem_q[tag_wr_q] <= iss_tag_q;
      end
      if (w_capture) begin
         res_data_q[res_wr_q] <= result_i;
         res_st_q[res_wr_q]   <= w_status;
         res_tag_q[res_wr_q]  <= w_cap_tag;
      end
   end

   assign rsp_result_o = rsp_valid_o ? res_data_q[res_rd_q] : '0;
   assign rsp_status_o = rsp_valid_o ? res_st_q[res_rd_q]   : '0;
   assign rsp_tag_o    = rsp_valid_o ? res_tag_q[res_rd_q]  : '0;

   // -------------------------------------------------------------------------
   // Sticky exception flags
   // -------------------------------------------------------------------------
`ifdef FPHUB_ISSUER_FFLAGS_EN
   logic [4:0] fflags_q, fflags_d;

   // A clear coinciding with a capture keeps only the newly captured flags.
   always_comb begin
      fflags_d = fflags_q;
      if (fflags_clr_i) begin
         fflags_d = w_capture ? w_status : 5'b0;
      end else if (w_capture) begin
         fflags_d = fflags_q | w_status;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fflags_q <= '0;
      end else begin
         fflags_q <= fflags_d;
      end
   end

   assign fflags_o = fflags_q;
`else
   logic w_unused_fflags_clr;
   assign w_unused_fflags_clr = fflags_clr_i;
   assign fflags_o            = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fphub_mult_issuer.md
# fphub_mult_issuer

Initiator-side front end for the HUB multiplier unit's FPnew-style port. It accepts tagged operand pairs from an upstream requester and drives `operands`/`op`/`in_valid` toward the multiplier. It collects `result`/`status` on the unit's output handshake and returns tagged, in-order responses through a result FIFO. With credit-based flow control, the multiplier's `out_ready` never needs to be deasserted for lack of space.

## Interface
- `WIDTH`, 16: operand/result width (E+M+1).
- `TAG_W`, 4: request tag width.
- `DEPTH`, 4: result FIFO entries; also max outstanding transactions (power of two, ≥2).

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  upstream request valid.
- `req_ready_o`  out  1  upstream request ready.
- `req_a_i`, `req_b_i`  in  WIDTH  HUB operands.
- `req_tag_i`  in  TAG_W  request tag.
- `flush_i`  in  1  abort all pending work (pulse).
- `operands_o`  out  3×WIDTH  [0]=A, [1]=B, [2]=0.
- `op_o`  out  fpnew_pkg::operation_e  constant MUL.
- `op_mod_o`  out  1  constant 0.
- `in_valid_o`  out  1  issue valid to multiplier.
- `in_ready_i`  in  1  multiplier ready.
- `flush_o`  out  1  flush to multiplier.
- `result_i`  in  WIDTH  multiplier result.
- `status_i`  in  fpnew_pkg::status_t  multiplier flags.
- `out_valid_i`  in  1  multiplier result valid.
- `out_ready_o`  out  1  result accept.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_result_o`  out  WIDTH  response result.
- `rsp_status_o`  out  5  response flags {NV,DZ,OF,UF,NX}.
- `rsp_tag_o`  out  TAG_W  response tag.
- `fflags_o`  out  5  sticky accumulated flags.
- `fflags_clr_i`  in  1  clear sticky flags.

## Operation
- States: RUN, FLUSH. Reset → RUN.
- Issue register (1 entry) holds {A, B, tag}.
  - Loaded on `req_valid_i && req_ready_o`.
  - `req_ready_o = (state==RUN) && (!iss_v || issue_fire)`.
- `in_valid_o = (state==RUN) && iss_v && (inflight + fifo_cnt < DEPTH)`. Operands stay stable while `in_valid_o && !in_ready_i`.
- `issue_fire = in_valid_o && in_ready_i`:
  - push the tag into the tag FIFO (DEPTH entries);
  - increment `inflight`.
- `out_ready_o = (state==RUN)`.
- `capture = out_valid_i && out_ready_o`:
  - pop the tag FIFO;
  - write {result_i, status_i, tag} into the result FIFO;
  - decrement `inflight`.
  - Capture is legal in the same cycle as `issue_fire` for the same transaction: a combinational unit with the tag FIFO empty bypasses the tag.
- Result FIFO: in order, circular pointers wrap at DEPTH.
  - Head drives the `rsp_*` outputs.
  - Pop on `rsp_valid_o && rsp_ready_i`.
  - Push and pop in the same cycle are allowed: count unchanged, including when full.
- Credit invariant: `inflight + fifo_cnt ≤ DEPTH` at all times. At DEPTH, `in_valid_o` = 0 until a response pops.
- `flush_i` in RUN:
  - next cycle state = FLUSH;
  - request accepted in the `flush_i` cycle is discarded.
- FLUSH (exactly 1 cycle):
  - `flush_o` = 1; `in_valid_o` = 0; `out_ready_o` = 0; `req_ready_o` = 0; `rsp_valid_o` = 0.
  - Issue register, tag FIFO, result FIFO and `inflight` are cleared.
  - Then RUN.
  - `flush_i` during FLUSH is ignored.
- Sticky flags: `fflags_o |= status` on each capture.
  - `fflags_clr_i` clears.
  - Clear and capture in the same cycle: result = captured status only.
  - Flush does not clear `fflags_o`.

## Timing
- Reset values of all outputs:
  - `in_valid_o`, `rsp_valid_o`, `flush_o`, `fflags_o`, `rsp_*` data = 0;
  - `req_ready_o` = 0 while `rst_i` is high, 1 in the first cycle after release;
  - `out_ready_o` = 1 after release;
  - `op_o` = MUL, `op_mod_o` = 0 always.
- Latency with a combinational multiplier:
  - request accepted cycle N;
  - `in_valid_o` and capture in cycle N+1;
  - `rsp_valid_o` in cycle N+2.
- Throughput is 1 per cycle when `rsp_ready_i` stays high.
- `rst_i` asserted mid-operation: all state is cleared asynchronously, and pending transactions are lost.

## Configuration
- `FPHUB_ISSUER_FFLAGS_EN`:
  - Defined: the sticky flag register and `fflags_clr_i` are active as described above.
  - Undefined: no flag register; `fflags_o` is tied to 0 and `fflags_clr_i` is ignored.
  - `rsp_status_o` is unaffected in both cases.

## Test plan
- Single request A=0x3C00, B=0x4000, tag=3, combinational unit returning 0x4000 → `in_valid_o` at N+1; `rsp_valid_o` at N+2 with result 0x4000, tag 3.
- 8 back-to-back requests with tags 0..7, `rsp_ready_i`=1 → 8 responses in tag order on consecutive cycles, no bubbles.
- `rsp_ready_i`=0 with DEPTH=4 and 6 requests → exactly 4 captures, then `in_valid_o`=0 and `req_ready_o`=0. After `rsp_ready_i`=1, the remaining 2 complete in order.
- `in_ready_i` held 0 for 3 cycles with a pending request → `operands_o` stable; a single issue occurs once ready rises.
- `flush_i` with 3 results queued → `flush_o`=1 for one cycle, `rsp_valid_o` 0 next cycle, FIFO empty, and a new request then completes normally.
- Captures with status NV=1, then OF=1 → `fflags_o`=5'b10100. `fflags_clr_i` coinciding with a capture of NX=1 → `fflags_o`=5'b00001.
